// File: rtl/pio_mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// pio_mem_access_ctrl_if
//
// Bundles the two sides of the PIO-to-RAM access controller:
//   PIO side : mem_addr, wr_data, cmd, start (from HPS output PIOs)
//              rd_data, busy, done, error    (to HPS input PIOs)
//   RAM side : ram_addr, ram_wdata, ram_we, ram_re (to the RAM port)
//              ram_rdata                        (from the RAM port)
//
// Modports:
//   slave  - the controller (consumes commands, drives the RAM port)
//   master - the environment (software PIOs plus the RAM itself)
//
// Handshake: a command is the rising edge of the start level, seen only
// while the controller is idle. busy is high from the accept edge until
// the edge that sets done. done and error are sticky until the next accept.
// ram_we and ram_re are single-cycle strobes and never high together.
// ---------------------------------------------------------------------------
interface pio_mem_access_ctrl_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        cmd;
    logic              start;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  mem_addr, wr_data, cmd, start, ram_rdata,
        output rd_data, busy, done, error, ram_addr, ram_wdata, ram_we, ram_re
    );

    modport master (
        output mem_addr, wr_data, cmd, start, ram_rdata,
        input  rd_data, busy, done, error, ram_addr, ram_wdata, ram_we, ram_re
    );
endinterface

// File: rtl/pio_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// pio_mem_access_ctrl
//
// Turns a software start-bit handshake into one read or write on a
// synchronous on-chip RAM port and reports status back to input PIOs.
//
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-high reset
//   bus       - pio_mem_access_ctrl_if.slave (PIO command/status + RAM port)
//   state_dbg - current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 FINISH)
//
// Commands (cmd): 00 nop, 01 read, 10 write, 11 reserved (flags error).
// Addresses >= MEM_DEPTH flag error for read/write and produce no strobe.
// ---------------------------------------------------------------------------
module pio_mem_access_ctrl #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int MEM_DEPTH  = 76800,
    parameter int RD_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    pio_mem_access_ctrl_if.slave bus,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_RSV = 2'b11;

    // WAIT counts down from RD_LATENCY-1 so data is sampled exactly
    // RD_LATENCY cycles after the ram_re cycle.
    localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY - 1);

    state_t            state, state_nxt;
    logic              start_q, start_q_nxt;
    logic [ADDR_W-1:0] addr_r, addr_nxt;
    logic [DATA_W-1:0] wdata_r, wdata_nxt;
    logic [1:0]        cmd_r, cmd_nxt;
    logic [2:0]        lat_cnt, lat_cnt_nxt;
    logic [DATA_W-1:0] rd_data_r, rd_data_nxt;
    logic              busy_r, busy_nxt;
    logic              done_r, done_nxt;
    logic              error_r, error_nxt;
    logic              we_c, re_c;
    logic              accept;
    logic              out_of_range;

    // Unsigned compare over the full address width.
    assign out_of_range = (32'(addr_r) >= 32'(MEM_DEPTH));

    // Only a rising edge of start while idle is a command; edges seen in
    // other states are dropped, not queued.
    assign accept = (state == S_IDLE) && bus.start && !start_q;

    always_comb begin
        state_nxt   = state;
        start_q_nxt = bus.start;
        addr_nxt    = addr_r;
        wdata_nxt   = wdata_r;
        cmd_nxt     = cmd_r;
        lat_cnt_nxt = lat_cnt;
        rd_data_nxt = rd_data_r;
        busy_nxt    = busy_r;
        done_nxt    = done_r;
        error_nxt   = error_r;
        we_c        = 1'b0;
        re_c        = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    addr_nxt  = bus.mem_addr;
                    wdata_nxt = bus.wr_data;
                    cmd_nxt   = bus.cmd;
                    done_nxt  = 1'b0;
                    error_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if ((cmd_r == CMD_RSV) ||
                    (((cmd_r == CMD_RD) || (cmd_r == CMD_WR)) && out_of_range)) begin
                    error_nxt = 1'b1;
                    state_nxt = S_FINISH;
                end else if (cmd_r == CMD_WR) begin
                    we_c      = 1'b1;
                    state_nxt = S_FINISH;
                end else if (cmd_r == CMD_RD) begin
                    re_c        = 1'b1;
                    lat_cnt_nxt = LAT_INIT;
                    state_nxt   = S_WAIT;
                end else begin
                    // CMD_NOP: complete without touching the RAM.
                    state_nxt = S_FINISH;
                end
            end

            S_WAIT: begin
                if (lat_cnt == 3'd0) begin
                    rd_data_nxt = bus.ram_rdata;
                    state_nxt   = S_FINISH;
                end else begin
                    lat_cnt_nxt = lat_cnt - 3'd1;
                end
            end

            S_FINISH: begin
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            // Reset high so a start level held through reset is not a command.
            start_q   <= 1'b1;
            addr_r    <= '0;
            wdata_r   <= '0;
            cmd_r     <= CMD_NOP;
            lat_cnt   <= '0;
            rd_data_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            state     <= state_nxt;
            start_q   <= start_q_nxt;
            addr_r    <= addr_nxt;
            wdata_r   <= wdata_nxt;
            cmd_r     <= cmd_nxt;
            lat_cnt   <= lat_cnt_nxt;
            rd_data_r <= rd_data_nxt;
            busy_r    <= busy_nxt;
            done_r    <= done_nxt;
            error_r   <= error_nxt;
        end
    end

    // Strobes are decoded from the ISSUE state, so they are high for exactly
    // one cycle and are low whenever the FSM sits in IDLE after reset.
    assign bus.ram_we    = we_c;
    assign bus.ram_re    = re_c;
    assign bus.ram_addr  = addr_r;
    assign bus.ram_wdata = wdata_r;
    assign bus.rd_data   = rd_data_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.error     = error_r;
    assign state_dbg     = state;

endmodule

// File: tb/tb_pio_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pio_mem_access_ctrl
//
// Directed bench for pio_mem_access_ctrl with a two-cycle-latency RAM model.
// Latency is counted in clock edges after the accept edge until busy falls.
// ---------------------------------------------------------------------------
module tb_pio_mem_access_ctrl;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;

    logic       clk;
    logic       reset;
    logic [1:0] state_dbg;

    pio_mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pio_mem_access_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_DEPTH (76800),
        .RD_LATENCY(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model (read latency 2) ----------------
    logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_pipe1, rd_pipe2;

    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
        rd_pipe1 <= ram_mem[bus.ram_addr];
        rd_pipe2 <= rd_pipe1;
    end
    assign bus.ram_rdata = rd_pipe2;

    // ---------------- strobe monitor ----------------
    int                we_total = 0;
    int                re_total = 0;
    int                both_cnt = 0;
    logic [ADDR_W-1:0] we_addr  = '0;
    logic [DATA_W-1:0] we_data  = '0;

    always @(posedge clk) begin
        if (bus.ram_we) begin
            we_total <= we_total + 1;
            we_addr  <= bus.ram_addr;
            we_data  <= bus.ram_wdata;
        end
        if (bus.ram_re) re_total <= re_total + 1;
        if (bus.ram_we && bus.ram_re) both_cnt <= both_cnt + 1;
    end

    // ---------------- scoreboard ----------------
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drops start, raises it with the given command, then follows the
    // transaction to completion and checks latency, strobes and status.
    // The expected rd_data afterwards is taken from exp_q.
    task automatic run_cmd(input string tag, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic [1:0] c,
                           input int exp_lat, input int exp_we, input int exp_re,
                           input logic exp_err);
        int we0, re0, cyc;
        logic [DATA_W-1:0] exp_rd;
        @(negedge clk);
        bus.mem_addr = addr;
        bus.wr_data  = data;
        bus.cmd      = c;
        bus.start    = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        we0 = we_total;
        re0 = re_total;
        @(negedge clk);
        check($sformatf("%s_busy_c1", tag), 32'(bus.busy), 32'd1);
        check($sformatf("%s_done_clr", tag), 32'(bus.done), 32'd0);
        check($sformatf("%s_err_clr", tag), 32'(bus.error), 32'd0);
        cyc = 1;
        while (bus.busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s_latency", tag), 32'(cyc - 1), 32'(exp_lat));
        check($sformatf("%s_done", tag), 32'(bus.done), 32'd1);
        check($sformatf("%s_error", tag), 32'(bus.error), 32'(exp_err));
        check($sformatf("%s_we_cnt", tag), 32'(we_total - we0), 32'(exp_we));
        check($sformatf("%s_re_cnt", tag), 32'(re_total - re0), 32'(exp_re));
        exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check($sformatf("%s_rd_data", tag), 32'(bus.rd_data), 32'(exp_rd));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int we0, re0;

        ram_mem[17'h12BFF] = 8'h3C;
        ram_mem[17'h00020] = 8'h5A;
        ram_mem[17'h00040] = 8'hC3;

        // Reset with start held high throughout.
        reset         = 1'b1;
        bus.start     = 1'b1;
        bus.mem_addr  = 17'h00055;
        bus.wr_data   = 8'h11;
        bus.cmd       = 2'b10;
        repeat (3) @(negedge clk);
        check("rst_rd_data", 32'(bus.rd_data), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_error", 32'(bus.error), 32'h0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
        check("rst_ram_wdata", 32'(bus.ram_wdata), 32'h0);
        check("rst_ram_we", 32'(bus.ram_we), 32'h0);
        check("rst_ram_re", 32'(bus.ram_re), 32'h0);
        check("rst_state", 32'(state_dbg), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("held_start_busy", 32'(bus.busy), 32'h0);
        check("held_start_done", 32'(bus.done), 32'h0);
        check("held_start_we", 32'(we_total), 32'h0);
        check("held_start_state", 32'(state_dbg), 32'h0);

        // Write 0xA5 to 0x00010.
        exp_q.push_back(8'h00);
        run_cmd("wr", 17'h00010, 8'hA5, 2'b10, 2, 1, 0, 1'b0);
        check("wr_addr", 32'(we_addr), 32'h00010);
        check("wr_data", 32'(we_data), 32'hA5);
        check("wr_mem", 32'(ram_mem[17'h00010]), 32'hA5);
        repeat (2) @(negedge clk);
        check("wr_addr_held", 32'(bus.ram_addr), 32'h00010);
        check("wr_wdata_held", 32'(bus.ram_wdata), 32'hA5);

        // Read at the last valid address.
        exp_q.push_back(8'h3C);
        run_cmd("rd_last", 17'h12BFF, 8'h00, 2'b01, 4, 0, 1, 1'b0);

        // Out of range read and write; rd_data keeps 0x3C.
        exp_q.push_back(8'h3C);
        run_cmd("rd_oor", 17'h12C00, 8'h00, 2'b01, 2, 0, 0, 1'b1);
        exp_q.push_back(8'h3C);
        run_cmd("wr_oor", 17'h12C00, 8'hEE, 2'b10, 2, 0, 0, 1'b1);

        // Reserved then nop.
        exp_q.push_back(8'h3C);
        run_cmd("rsv", 17'h00005, 8'h00, 2'b11, 2, 0, 0, 1'b1);
        exp_q.push_back(8'h3C);
        run_cmd("nop", 17'h00005, 8'h00, 2'b00, 2, 0, 0, 1'b0);

        // Read back the earlier write.
        exp_q.push_back(8'hA5);
        run_cmd("rd_back", 17'h00010, 8'h00, 2'b01, 4, 0, 1, 1'b0);

        // Start edges while busy are ignored and not queued.
        @(negedge clk);
        bus.mem_addr = 17'h00020;
        bus.cmd      = 2'b01;
        bus.start    = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        we0 = we_total;
        re0 = re_total;
        @(negedge clk);                     // ISSUE
        bus.mem_addr = 17'h00030;
        bus.wr_data  = 8'h77;
        bus.cmd      = 2'b10;
        bus.start    = 1'b0;
        @(negedge clk);                     // WAIT
        check("tog_state_wait", 32'(state_dbg), 32'h2);
        bus.start = 1'b1;
        @(negedge clk);                     // WAIT
        bus.start = 1'b0;
        @(negedge clk);                     // FINISH
        bus.start = 1'b1;
        repeat (5) @(negedge clk);
        check("tog_busy", 32'(bus.busy), 32'h0);
        check("tog_done", 32'(bus.done), 32'h1);
        check("tog_rd_data", 32'(bus.rd_data), 32'h5A);
        check("tog_re_cnt", 32'(re_total - re0), 32'h1);
        check("tog_we_cnt", 32'(we_total - we0), 32'h0);
        exp_q.push_back(8'h5A);
        run_cmd("tog_next", 17'h00030, 8'h77, 2'b10, 2, 1, 0, 1'b0);
        check("tog_next_mem", 32'(ram_mem[17'h00030]), 32'h77);

        // Reset in the middle of a read.
        @(negedge clk);
        bus.mem_addr = 17'h00040;
        bus.cmd      = 2'b01;
        bus.start    = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);                     // ISSUE
        @(negedge clk);                     // WAIT
        check("mid_state_wait", 32'(state_dbg), 32'h2);
        reset = 1'b1;
        @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'h0);
        check("mid_done", 32'(bus.done), 32'h0);
        check("mid_ram_re", 32'(bus.ram_re), 32'h0);
        check("mid_state", 32'(state_dbg), 32'h0);
        check("mid_rd_data", 32'(bus.rd_data), 32'h0);
        reset     = 1'b0;
        bus.start = 1'b0;
        exp_q.push_back(8'h3C);
        run_cmd("post_rst_rd", 17'h12BFF, 8'h00, 2'b01, 4, 0, 1, 1'b0);

        check("never_both_strobes", 32'(both_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
